axi_wr_arbiter: RTL and testbench
=================================

AXI_WR_ARBITER -- requirements
Module: axi_wr_arbiter

Interface
REQ-001: Parameter DATA_WIDTH, default 32, width of write data on all ports.
REQ-002: Parameter ADDR_WIDTH, default 16, width of burst start address on all ports.
REQ-003: ACLK  in  1  single clock; all state updates on rising edge.
REQ-004: ARESETn  in  1  reset, synchronous, active-low.
REQ-005: req  in  2  per-requester burst request; bit i = requester i.
REQ-006: req_addr  in  2*ADDR_WIDTH  packed start addresses; slice i = requester i.
REQ-007: req_len  in  16  packed AWLEN values, 8 bits per requester.
REQ-008: req_size  in  6  packed AWSIZE values, 3 bits per requester.
REQ-009: gnt  out  2  one-cycle one-hot pulse, command of requester i accepted.
REQ-010: m_wdata  in  2*DATA_WIDTH  packed per-requester write data.
REQ-011: m_wvalid  in  2 / m_wready  out  2  per-requester beat handshake.
REQ-012: m_bresp  out  2  response to current owner / m_bvalid  out  2  one-cycle response pulse, bit i = owner.
REQ-013: AWADDR out ADDR_WIDTH, AWLEN out 8, AWSIZE out 3, AWVALID out 1, AWREADY in 1  AXI4 write-address channel to slave.
REQ-014: WDATA out DATA_WIDTH, WLAST out 1, WVALID out 1, WREADY in 1  AXI4 write-data channel.
REQ-015: BRESP in 2, BVALID in 1, BREADY out 1  AXI4 write-response channel.

Function
REQ-016: FSM states IDLE, ADDR, DATA, RESP; exactly one burst in flight at any time.
REQ-017: IDLE: if any req bit set, select owner by round-robin pointer, latch its addr/len/size, pulse gnt[owner], go ADDR next cycle.
REQ-018: Round-robin: both req set -> grant requester != last owner; after reset, requester 0 wins the tie; lone requester is granted back-to-back.
REQ-019: ADDR: AWVALID=1 with latched AWADDR/AWLEN/AWSIZE held stable until AWREADY; on AWVALID&&AWREADY go DATA, beat counter cleared to 0.
REQ-020: DATA: WDATA = m_wdata[owner], WVALID = m_wvalid[owner], m_wready[owner] = WREADY; non-owner m_wready = 0.
REQ-021: WLAST = 1 when beat counter == latched AWLEN; counter increments by 1 on each WVALID&&WREADY.
REQ-022: Handshake with WLAST=1 -> RESP next cycle; AWLEN=0 is a single-beat burst with WLAST on first beat.
REQ-023: RESP: BREADY=1; on BVALID, m_bvalid[owner] pulses one cycle, m_bresp = BRESP, go IDLE next cycle; pointer updated to owner.
REQ-024: No combinational path from req to AWVALID; gnt-to-AWVALID latency exactly 1 cycle.
REQ-025: Requester changes to req/req_addr/req_len/req_size after gnt do not affect the burst in flight.
REQ-026: Outside their states AWVALID, WVALID, WLAST, BREADY, m_wready, m_bvalid, gnt = 0.
REQ-027: m_wvalid deassertion by owner mid-burst stalls beat counter; no timeout.

Reset
REQ-028: ARESETn low at a rising edge: FSM -> IDLE, pointer -> requester 0, beat counter -> 0, latched command -> 0.
REQ-029: Output reset values: gnt=0, m_wready=0, m_bvalid=0, m_bresp=0, AWADDR=0, AWLEN=0, AWSIZE=0, AWVALID=0, WDATA=0 (driven 0 in IDLE), WLAST=0, WVALID=0, BREADY=0.
REQ-030: Reset mid-burst abandons the burst; no m_bvalid pulse is issued for it.

Verification
REQ-031: req=01, addr=0x0010, len=3, size=2, slave always ready -> gnt=01 one cycle, AWADDR=0x0010 AWLEN=3, 4 W beats, WLAST on 4th, m_bvalid=01 with m_bresp=BRESP.
REQ-032: req=11 held after reset -> gnt sequence 01, 10, 01 across three consecutive bursts.
REQ-033: len=0 burst -> exactly one W beat with WLAST=1, then RESP.
REQ-034: AWREADY held low 5 cycles -> AWVALID stays 1, AWADDR/AWLEN constant, DATA not entered until handshake.
REQ-035: owner m_wvalid toggled 1,0,1,0 with len=1 -> WLAST only on 2nd accepted beat; non-owner m_wready stays 0.
REQ-036: ARESETn low during DATA beat 2 of len=7 -> next cycle all outputs at reset values, no m_bvalid, next req=10 granted to requester 1.

Source files
------------

// File: rtl/axi_wr_arbiter.sv
// Two-requester AXI4 write arbiter. Requesters take turns round-robin, and
// one burst at a time is forwarded to a single AXI4 slave.
module axi_wr_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                    ACLK,
  input  logic                    ARESETn,
  input  logic [1:0]              req,
  input  logic [2*ADDR_WIDTH-1:0] req_addr,
  input  logic [15:0]             req_len,
  input  logic [5:0]              req_size,
  output logic [1:0]              gnt,
  input  logic [2*DATA_WIDTH-1:0] m_wdata,
  input  logic [1:0]              m_wvalid,
  output logic [1:0]              m_wready,
  output logic [1:0]              m_bresp,
  output logic [1:0]              m_bvalid,
  output logic [ADDR_WIDTH-1:0]   AWADDR,
  output logic [7:0]              AWLEN,
  output logic [2:0]              AWSIZE,
  output logic                    AWVALID,
  input  logic                    AWREADY,
  output logic [DATA_WIDTH-1:0]   WDATA,
  output logic                    WLAST,
  output logic                    WVALID,
  input  logic                    WREADY,
  input  logic [1:0]              BRESP,
  input  logic                    BVALID,
  output logic                    BREADY
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

  state_t                state, state_nxt;
  logic                  owner;
  logic                  prio;   // requester that wins a tie
  logic                  sel;
  logic [7:0]            beat;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [7:0]            len_q;
  logic [2:0]            size_q;

  assign AWADDR = addr_q;
  assign AWLEN  = len_q;
  assign AWSIZE = size_q;

  always_comb begin
    sel = (req == 2'b11) ? prio : req[1];
  end

  always_comb begin
    state_nxt = state;
    gnt       = '0;
    AWVALID   = 1'b0;
    WDATA     = '0;
    WVALID    = 1'b0;
    WLAST     = 1'b0;
    m_wready  = '0;
    BREADY    = 1'b0;
    m_bvalid  = '0;
    m_bresp   = '0;
    case (state)
      IDLE: begin
        if (|req) begin
          gnt[sel]  = 1'b1;
          state_nxt = ADDR;
        end
      end
      ADDR: begin
        AWVALID = 1'b1;
        if (AWREADY) state_nxt = DATA;
      end
      DATA: begin
        WDATA           = owner ? m_wdata[2*DATA_WIDTH-1:DATA_WIDTH] : m_wdata[DATA_WIDTH-1:0];
        WVALID          = m_wvalid[owner];
        m_wready[owner] = WREADY;
        WLAST           = (beat == len_q);
        if (WVALID && WREADY && WLAST) state_nxt = RESP;
      end
      RESP: begin
        BREADY = 1'b1;
        if (BVALID) begin
          m_bvalid[owner] = 1'b1;
          m_bresp         = BRESP;
          state_nxt       = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state  <= IDLE;
      owner  <= 1'b0;
      prio   <= 1'b0;
      beat   <= '0;
      addr_q <= '0;
      len_q  <= '0;
      size_q <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (|req) begin
            owner  <= sel;
            addr_q <= sel ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : req_addr[ADDR_WIDTH-1:0];
            len_q  <= sel ? req_len[15:8] : req_len[7:0];
            size_q <= sel ? req_size[5:3] : req_size[2:0];
          end
        end
        ADDR: if (AWREADY) beat <= '0;
        DATA: if (WVALID && WREADY) beat <= beat + 8'd1;
        // The finished owner loses the next tie.
        RESP: if (BVALID) prio <= ~owner;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_wr_arbiter.sv
// Bench for axi_wr_arbiter: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a transaction-level model.
module tb_axi_wr_arbiter;

  localparam int DW = 32;
  localparam int AW = 16;

  logic            ACLK;
  logic            ARESETn;
  logic [1:0]      req;
  logic [2*AW-1:0] req_addr;
  logic [15:0]     req_len;
  logic [5:0]      req_size;
  logic [1:0]      gnt;
  logic [2*DW-1:0] m_wdata;
  logic [1:0]      m_wvalid;
  logic [1:0]      m_wready;
  logic [1:0]      m_bresp;
  logic [1:0]      m_bvalid;
  logic [AW-1:0]   AWADDR;
  logic [7:0]      AWLEN;
  logic [2:0]      AWSIZE;
  logic            AWVALID;
  logic            AWREADY;
  logic [DW-1:0]   WDATA;
  logic            WLAST;
  logic            WVALID;
  logic            WREADY;
  logic [1:0]      BRESP;
  logic            BVALID;
  logic            BREADY;

  axi_wr_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .req(req), .req_addr(req_addr), .req_len(req_len), .req_size(req_size),
    .gnt(gnt),
    .m_wdata(m_wdata), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid),
    .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY)
  );

  int errors = 0;
  int checks = 0;

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Transaction-level model: tracks which burst is outstanding and which
  // phase of it the slave protocol has reached.
  bit         mvalid = 0;
  bit         busy, aw_ph, w_ph, b_ph;
  bit         mown, last, have_last;
  logic [AW-1:0] eaddr;
  logic [7:0] elen, nbeat;
  logic [2:0] esize;
  logic [1:0] egnt, emr, ebv;
  logic       win;

  initial begin
    forever begin
      @(negedge ACLK);
      if (mvalid) begin
        win  = (req == 2'b11) ? (have_last ? ~last : 1'b0) : req[1];
        egnt = '0;
        if (!busy && req != 2'b00) egnt[win] = 1'b1;
        chk("gnt", 64'(gnt), 64'(egnt));
        chk("awvalid", 64'(AWVALID), 64'(aw_ph));
        if (aw_ph) chk("aw_cmd", 64'({AWADDR, AWLEN, AWSIZE}), 64'({eaddr, elen, esize}));
        chk("wvalid", 64'(WVALID), 64'(w_ph ? m_wvalid[mown] : 1'b0));
        if (w_ph) chk("wdata", 64'(WDATA), 64'(mown ? m_wdata[2*DW-1:DW] : m_wdata[DW-1:0]));
        else if (!busy) chk("wdata_idle", 64'(WDATA), 64'd0);
        chk("wlast", 64'(WLAST), 64'(w_ph && nbeat == elen));
        emr = '0;
        if (w_ph) emr[mown] = WREADY;
        chk("m_wready", 64'(m_wready), 64'(emr));
        chk("bready", 64'(BREADY), 64'(b_ph));
        ebv = '0;
        if (b_ph && BVALID) ebv[mown] = 1'b1;
        chk("m_bvalid", 64'(m_bvalid), 64'(ebv));
        if (b_ph && BVALID) chk("m_bresp", 64'(m_bresp), 64'(BRESP));

        if (egnt != 2'b00) begin
          busy  = 1; aw_ph = 1; mown = win;
          eaddr = win ? req_addr[2*AW-1:AW] : req_addr[AW-1:0];
          elen  = win ? req_len[15:8] : req_len[7:0];
          esize = win ? req_size[5:3] : req_size[2:0];
        end else if (aw_ph && AWREADY) begin
          aw_ph = 0; w_ph = 1; nbeat = '0;
        end else if (w_ph && m_wvalid[mown] && WREADY) begin
          if (nbeat == elen) begin w_ph = 0; b_ph = 1; end
          else nbeat = nbeat + 8'd1;
        end else if (b_ph && BVALID) begin
          b_ph = 0; busy = 0; last = mown; have_last = 1;
        end
      end
      if (!ARESETn) begin
        mvalid = 1; busy = 0; aw_ph = 0; w_ph = 0; b_ph = 0;
        have_last = 0; last = 0; mown = 0; nbeat = '0;
      end
    end
  end

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic get_gnt(output logic [1:0] g);
    @(negedge ACLK);
    g = gnt;
    tick();
  endtask

  // Follows a granted burst from its address cycle until the response pulse.
  task automatic watch(input int awdelay, input bit toggle, input bit own,
                       output int beats, output int last_at, output int aw_cycles,
                       output bit addr_moved, output bit early_w, output bit other_rdy,
                       output logic [1:0] bv, output logic [1:0] br);
    logic [AW-1:0] a0;
    logic [7:0]    l0;
    bit            aw_done, found;
    beats = 0; last_at = 0; aw_cycles = 0; addr_moved = 0; early_w = 0;
    other_rdy = 0; bv = '0; br = '0; aw_done = 0; found = 0;
    a0 = AWADDR;
    l0 = AWLEN;
    for (int k = 0; k < 60 && !found; k++) begin
      AWREADY = (k >= awdelay);
      if (toggle) m_wvalid = (k % 2 == 0) ? 2'b11 : 2'b00;
      @(negedge ACLK);
      if (AWVALID) begin
        aw_cycles++;
        if (AWADDR != a0 || AWLEN != l0) addr_moved = 1;
        if (AWREADY) aw_done = 1;
      end
      if (m_wready[~own]) other_rdy = 1;
      if (WVALID && !aw_done) early_w = 1;
      if (WVALID && WREADY) begin
        beats++;
        if (WLAST) last_at = (last_at == 0) ? beats : -1;
      end
      if (m_bvalid != 2'b00) begin
        bv = m_bvalid; br = m_bresp; found = 1;
      end
      tick();
    end
    chk("watch_done", 64'(found), 64'd1);
    m_wvalid = 2'b11;
    AWREADY  = 1'b1;
  endtask

  logic [1:0] g, g1, g2, g3, bv, br;
  int beats, last_at, awc;
  bit moved, early, orr;

  initial begin
    ARESETn = 0; req = '0; req_addr = '0; req_len = '0; req_size = '0;
    m_wdata = '0; m_wvalid = '0; AWREADY = 0; WREADY = 0; BRESP = '0; BVALID = 0;
    repeat (3) tick();
    @(negedge ACLK);
    chk("rst_ctrl", 64'({gnt, m_wready, m_bvalid, m_bresp, AWVALID, WVALID, WLAST, BREADY}), 64'd0);
    chk("rst_cmd", 64'({AWADDR, AWLEN, AWSIZE}), 64'd0);
    chk("rst_wdata", 64'(WDATA), 64'd0);
    tick();
    ARESETn = 1;
    tick();

    // Single 4-beat burst from requester 0, slave always ready.
    AWREADY = 1; WREADY = 1; BVALID = 1; BRESP = 2'b10; m_wvalid = 2'b11;
    m_wdata = {32'hbbbb_0001, 32'haaaa_0001};
    req_addr = {16'h0000, 16'h0010}; req_len = {8'd0, 8'd3}; req_size = {3'd0, 3'd2};
    req = 2'b01;
    get_gnt(g);
    req = 2'b00;
    chk("t1_gnt", 64'(g), 64'd1);
    chk("t1_awvalid", 64'(AWVALID), 64'd1);
    chk("t1_awaddr", 64'(AWADDR), 64'h10);
    chk("t1_awlen", 64'(AWLEN), 64'd3);
    chk("t1_awsize", 64'(AWSIZE), 64'd2);
    watch(0, 0, 1'b0, beats, last_at, awc, moved, early, orr, bv, br);
    chk("t1_beats", 64'(beats), 64'd4);
    chk("t1_wlast_at", 64'(last_at), 64'd4);
    chk("t1_bvalid", 64'(bv), 64'd1);
    chk("t1_bresp", 64'(br), 64'd2);

    // Single-beat burst from requester 1.
    BRESP = 2'b01;
    req_addr = {16'h1234, 16'h0000}; req_len = {8'd0, 8'd5};
    req = 2'b10;
    get_gnt(g);
    req = 2'b00;
    chk("t2_gnt", 64'(g), 64'd2);
    watch(0, 0, 1'b1, beats, last_at, awc, moved, early, orr, bv, br);
    chk("t2_beats", 64'(beats), 64'd1);
    chk("t2_wlast_at", 64'(last_at), 64'd1);
    chk("t2_bvalid", 64'(bv), 64'd2);
    chk("t2_bresp", 64'(br), 64'd1);

    // Address channel stalled for 5 cycles.
    req_addr = {16'h0000, 16'h0abc}; req_len = {8'd0, 8'd2};
    req = 2'b01;
    get_gnt(g);
    req = 2'b00;
    req_addr = {16'hffff, 16'hffff}; req_len = 16'hffff;
    watch(5, 0, 1'b0, beats, last_at, awc, moved, early, orr, bv, br);
    chk("t3_aw_cycles", 64'(awc), 64'd6);
    chk("t3_addr_stable", 64'(moved), 64'd0);
    chk("t3_no_early_data", 64'(early), 64'd0);
    chk("t3_beats", 64'(beats), 64'd3);

    // Owner toggles m_wvalid on a 2-beat burst.
    req_len = {8'd1, 8'd0};
    req = 2'b10;
    get_gnt(g);
    req = 2'b00;
    chk("t4_gnt", 64'(g), 64'd2);
    watch(0, 1, 1'b1, beats, last_at, awc, moved, early, orr, bv, br);
    chk("t4_beats", 64'(beats), 64'd2);
    chk("t4_wlast_at", 64'(last_at), 64'd2);
    chk("t4_other_wready", 64'(orr), 64'd0);

    // Both requesting from reset: alternating grants.
    ARESETn = 0;
    tick();
    ARESETn = 1;
    req_len = '0;
    req = 2'b11;
    get_gnt(g1);
    watch(0, 0, g1[1], beats, last_at, awc, moved, early, orr, bv, br);
    get_gnt(g2);
    watch(0, 0, g2[1], beats, last_at, awc, moved, early, orr, bv, br);
    get_gnt(g3);
    req = 2'b00;
    watch(0, 0, g3[1], beats, last_at, awc, moved, early, orr, bv, br);
    chk("t5_gnt1", 64'(g1), 64'd1);
    chk("t5_gnt2", 64'(g2), 64'd2);
    chk("t5_gnt3", 64'(g3), 64'd1);

    // Reset during beat 2 of an 8-beat burst.
    req_len = {8'd0, 8'd7};
    req = 2'b01;
    get_gnt(g);
    req = 2'b00;
    tick();
    tick();
    ARESETn = 0;
    @(negedge ACLK);
    chk("t6_beat2_live", 64'({WVALID, WLAST}), 64'd2);
    tick();
    @(negedge ACLK);
    chk("t6_rst_ctrl", 64'({gnt, m_wready, m_bvalid, m_bresp, AWVALID, WVALID, WLAST, BREADY}), 64'd0);
    chk("t6_rst_cmd", 64'({AWADDR, AWLEN, AWSIZE}), 64'd0);
    chk("t6_rst_wdata", 64'(WDATA), 64'd0);
    tick();
    ARESETn = 1;
    req = 2'b10;
    get_gnt(g);
    req = 2'b00;
    chk("t6_gnt_after", 64'(g), 64'd2);
    watch(0, 0, 1'b1, beats, last_at, awc, moved, early, orr, bv, br);

    // Randomized traffic; the model checks every cycle.
    for (int i = 0; i < 3000; i++) begin
      req      = 2'($urandom);
      req_addr = 32'($urandom);
      req_len  = {8'($urandom_range(0, 7)), 8'($urandom_range(0, 7))};
      req_size = 6'($urandom);
      m_wdata  = {$urandom, $urandom};
      m_wvalid = 2'($urandom) | 2'($urandom);
      AWREADY  = ($urandom_range(0, 3) != 0);
      WREADY   = ($urandom_range(0, 3) != 0);
      BVALID   = ($urandom_range(0, 2) == 0);
      BRESP    = 2'($urandom);
      ARESETn  = ($urandom_range(0, 399) != 0);
      tick();
    end
    ARESETn = 1;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
